// File: rtl/ring_port_arbiter.sv
// Three-way ring port arbiter: round-robin packet grant and wormhole lock until tail. Registered flit out, latency 1.
// POP is never asserted while DST_FULL is high. Optional watchdog (ARB_WATCHDOG_EN) unlocks a stalled owner.
module ring_port_arbiter #(
  parameter logic [7:0] WD_LIMIT = 8'd255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  EMPTY,
  input  logic [18:0] DIN0,
  input  logic [18:0] DIN1,
  input  logic [18:0] DIN2,
  input  logic        DST_FULL,
  output logic [2:0]  POP,
  output logic [18:0] DOUT,
  output logic        DOUT_VALID,
  output logic        LOCKED,
  output logic [1:0]  OWNER,
  output logic        PROTO_ERR,
  output logic        TIMEOUT
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  owner_q, owner_d;
  logic [18:0] dout_q, dout_d;
  logic        dout_vld_q, dout_vld_d;
  logic        proto_err_q, proto_err_d;

  logic [1:0]  idx1, idx2;
  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic        pop_en;
  logic [1:0]  pop_idx;
  logic [18:0] sel_flit;
  logic [1:0]  sel_ctrl;
  logic        fwd;

  // Round-robin search starting at rr_ptr, wrapping modulo 3.
  always_comb begin
    idx1      = inc3(rr_ptr_q);
    idx2      = inc3(idx1);
    grant_vld = 1'b1;
    grant_idx = rr_ptr_q;
    if (!EMPTY[rr_ptr_q]) begin
      grant_idx = rr_ptr_q;
    end else if (!EMPTY[idx1]) begin
      grant_idx = idx1;
    end else if (!EMPTY[idx2]) begin
      grant_idx = idx2;
    end else begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    pop_idx = (state_q == S_IDLE) ? grant_idx : owner_q;
    pop_en  = 1'b0;
    if (!RST && !DST_FULL) begin
      pop_en = (state_q == S_IDLE) ? grant_vld : !EMPTY[owner_q];
    end
    POP = pop_en ? (3'b001 << pop_idx) : 3'b000;
    case (pop_idx)
      2'd0:    sel_flit = DIN0;
      2'd1:    sel_flit = DIN1;
      default: sel_flit = DIN2;
    endcase
    sel_ctrl = sel_flit[17:16];
  end

`ifdef ARB_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    proto_err_d = proto_err_q;
    fwd         = 1'b0;
    if (pop_en) begin
      if (state_q == S_IDLE) begin
        owner_d = grant_idx;
        case (sel_ctrl)
          CTRL_HEAD: begin
            state_d = S_LOCKED;
            fwd     = 1'b1;
          end
          CTRL_BODY, CTRL_TAIL: begin
            fwd         = 1'b1;
            proto_err_d = 1'b1;
            rr_ptr_d    = inc3(grant_idx);
          end
          default: fwd = 1'b0;
        endcase
      end else begin
        case (sel_ctrl)
          CTRL_BODY: fwd = 1'b1;
          CTRL_TAIL: begin
            fwd      = 1'b1;
            state_d  = S_IDLE;
            rr_ptr_d = inc3(owner_q);
          end
          CTRL_HEAD: begin
            fwd         = 1'b1;
            proto_err_d = 1'b1;
          end
          default: fwd = 1'b0;
        endcase
      end
    end
    dout_d     = fwd ? sel_flit : dout_q;
    dout_vld_d = fwd;

`ifdef ARB_WATCHDOG_EN
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    // An owner with nothing to send while locked counts toward the stall limit.
    if ((state_q == S_LOCKED) && EMPTY[owner_q]) begin
      if ((wd_cnt_q + 8'd1) == WD_LIMIT) begin
        state_d   = S_IDLE;
        timeout_d = 1'b1;
        rr_ptr_d  = inc3(owner_q);
        wd_cnt_d  = 8'd0;
      end else begin
        wd_cnt_d = wd_cnt_q + 8'd1;
      end
    end else if (pop_en || (state_d != S_LOCKED)) begin
      wd_cnt_d = 8'd0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 2'd0;
      owner_q     <= 2'd0;
      dout_q      <= 19'h0;
      dout_vld_q  <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      wd_cnt_q    <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      proto_err_q <= proto_err_d;
`ifdef ARB_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_vld_q;
  assign LOCKED     = (state_q == S_LOCKED);
  assign OWNER      = owner_q;
  assign PROTO_ERR  = proto_err_q;

`ifdef ARB_WATCHDOG_EN
  assign TIMEOUT = timeout_q;
`else
  // Without the watchdog the limit has no consumer.
  logic unused_wd_limit;
  assign unused_wd_limit = ^WD_LIMIT;
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_ring_port_arbiter.sv
// Directed bench for ring_port_arbiter; bench-side queues stand in for the requester FIFOs.
module tb_ring_port_arbiter;

  logic        CLK;
  logic        RST;
  logic [2:0]  EMPTY;
  logic [18:0] DIN0, DIN1, DIN2;
  logic        DST_FULL;
  logic [2:0]  POP;
  logic [18:0] DOUT;
  logic        DOUT_VALID;
  logic        LOCKED;
  logic [1:0]  OWNER;
  logic        PROTO_ERR;
  logic        TIMEOUT;

  ring_port_arbiter #(.WD_LIMIT(8'd10)) dut (
    .CLK(CLK), .RST(RST), .EMPTY(EMPTY),
    .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2),
    .DST_FULL(DST_FULL), .POP(POP), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .LOCKED(LOCKED), .OWNER(OWNER), .PROTO_ERR(PROTO_ERR), .TIMEOUT(TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [1:0] C_IDLE = 2'b00;
  localparam logic [1:0] C_HEAD = 2'b01;
  localparam logic [1:0] C_BODY = 2'b10;
  localparam logic [1:0] C_TAIL = 2'b11;

  logic [18:0] q0[$];
  logic [18:0] q1[$];
  logic [18:0] q2[$];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [18:0] fl(input logic d, input logic [1:0] c, input logic [15:0] p);
    return {d, c, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive();
    EMPTY = {q2.size() == 0, q1.size() == 0, q0.size() == 0};
    DIN0  = (q0.size() != 0) ? q0[0] : 19'h0;
    DIN1  = (q1.size() != 0) ? q1[0] : 19'h0;
    DIN2  = (q2.size() != 0) ? q2[0] : 19'h0;
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic tick();
    logic [2:0] p;
    p = POP;
    @(posedge CLK);
    if (p[0] && q0.size() != 0) q0.delete(0);
    if (p[1] && q1.size() != 0) q1.delete(0);
    if (p[2] && q2.size() != 0) q2.delete(0);
    #1;
    drive();
    #1;
  endtask

  logic [2:0]  ap[8];
  logic [18:0] ad[8];
  logic [18:0] held;

  initial begin
    RST      = 1'b1;
    DST_FULL = 1'b0;
    settle();

    // Reset: POP suppressed even with data waiting
    q0.push_back(fl(1'b0, C_HEAD, 16'h0A00));
    settle();
    check("pop_in_rst", POP, 3'b000);
    tick();
    tick();
    check("rst_locked", LOCKED, 0);
    check("rst_owner", OWNER, 0);
    check("rst_dout", DOUT, 0);
    check("rst_dv", DOUT_VALID, 0);
    check("rst_perr", PROTO_ERR, 0);
    check("rst_tmo", TIMEOUT, 0);
    RST = 1'b0;

    // Round robin with 2-flit packets from all requesters
    q0.push_back(fl(1'b0, C_TAIL, 16'h0A01));
    q1.push_back(fl(1'b1, C_HEAD, 16'h1A00)); q1.push_back(fl(1'b0, C_TAIL, 16'h1A01));
    q2.push_back(fl(1'b0, C_HEAD, 16'h2A00)); q2.push_back(fl(1'b1, C_TAIL, 16'h2A01));
    q0.push_back(fl(1'b0, C_HEAD, 16'h0B00)); q0.push_back(fl(1'b0, C_TAIL, 16'h0B01));
    ap = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
    ad = '{19'h10A00, 19'h30A01, 19'h51A00, 19'h31A01,
           19'h12A00, 19'h72A01, 19'h10B00, 19'h30B01};
    settle();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_pop%0d", k), POP, ap[k]);
      tick();
      check($sformatf("rr_dv%0d", k), DOUT_VALID, 1);
      check($sformatf("rr_dout%0d", k), DOUT, ad[k]);
      if (k == 0) check("rr_lock_after_head", LOCKED, 1);
      if (k == 1) check("rr_unlock_after_tail", LOCKED, 0);
    end
    check("rr_drained_pop", POP, 3'b000);
    tick();
    check("rr_drained_dv", DOUT_VALID, 0);
    check("rr_hold_dout", DOUT, 19'h30B01);

    // Req1 long packet holds off req0; rr_ptr is 1 here
    q1.push_back(fl(1'b0, C_HEAD, 16'h2100)); q1.push_back(fl(1'b0, C_BODY, 16'h2101));
    q1.push_back(fl(1'b0, C_BODY, 16'h2102)); q1.push_back(fl(1'b0, C_TAIL, 16'h2103));
    q0.push_back(fl(1'b0, C_HEAD, 16'h2000)); q0.push_back(fl(1'b0, C_TAIL, 16'h2001));
    settle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lock_pop%0d", k), POP, 3'b010);
      tick();
      check($sformatf("lock_dout%0d", k), DOUT, {3'b0, 16'h2100 + 16'(k)} | (k == 0 ? 19'h10000 : (k == 3 ? 19'h30000 : 19'h20000)));
    end
    check("lock_next_req0", POP, 3'b001);
    tick();
    check("lock_req0_owner", OWNER, 0);
    tick();
    check("lock_req0_tail", DOUT, 19'h32001);

    // Backpressure mid-packet; rr_ptr is 1
    q1.push_back(fl(1'b0, C_HEAD, 16'h3100)); q1.push_back(fl(1'b0, C_BODY, 16'h3101));
    q1.push_back(fl(1'b0, C_BODY, 16'h3102)); q1.push_back(fl(1'b0, C_BODY, 16'h3103));
    q1.push_back(fl(1'b0, C_TAIL, 16'h3104));
    settle();
    tick();
    tick();
    check("bp_pre_dout", DOUT, 19'h23101);
    DST_FULL = 1'b1;
    settle();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_pop%0d", k), POP, 3'b000);
      tick();
      check($sformatf("bp_dv%0d", k), DOUT_VALID, 0);
      check($sformatf("bp_dout%0d", k), DOUT, 19'h23101);
    end
    check("bp_locked", LOCKED, 1);
    DST_FULL = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp_rel_dv%0d", k), DOUT_VALID, 1);
      check($sformatf("bp_rel_dout%0d", k), DOUT, (k == 2) ? 19'h33104 : (19'h23102 + 19'(k)));
    end
    check("bp_end_unlocked", LOCKED, 0);

    // Protocol error and idle-flit discard; rr_ptr is 2
    q2.push_back(fl(1'b1, C_BODY, 16'h4444));
    settle();
    check("perr_pop", POP, 3'b100);
    tick();
    check("perr_dout", DOUT, 19'h64444);
    check("perr_dv", DOUT_VALID, 1);
    check("perr_flag", PROTO_ERR, 1);
    check("perr_unlocked", LOCKED, 0);
    q2.push_back(fl(1'b0, C_IDLE, 16'h5555));
    settle();
    check("idle_pop", POP, 3'b100);
    tick();
    check("idle_dv", DOUT_VALID, 0);
    check("idle_hold_dout", DOUT, 19'h64444);
    tick();
    tick();
    check("perr_sticky", PROTO_ERR, 1);

    // Reset mid-packet while req2 owns the output; rr_ptr is 0
    q2.push_back(fl(1'b0, C_HEAD, 16'h6600)); q2.push_back(fl(1'b0, C_BODY, 16'h6601));
    q2.push_back(fl(1'b0, C_BODY, 16'h6602));
    settle();
    tick();
    check("rstm_owner2", OWNER, 2);
    q0.push_back(fl(1'b0, C_HEAD, 16'h7000)); q0.push_back(fl(1'b0, C_TAIL, 16'h7001));
    q1.push_back(fl(1'b0, C_HEAD, 16'h7100)); q1.push_back(fl(1'b0, C_TAIL, 16'h7101));
    settle();
    check("rstm_only_owner", POP, 3'b100);
    tick();
    RST = 1'b1;
    q2.delete();
    settle();
    check("rstm_pop_zero", POP, 3'b000);
    tick();
    RST = 1'b0;
    settle();
    check("rstm_locked", LOCKED, 0);
    check("rstm_owner", OWNER, 0);
    check("rstm_dout", DOUT, 0);
    check("rstm_perr_clr", PROTO_ERR, 0);
    check("rstm_grant0", POP, 3'b001);
    tick();
    check("rstm_dout_req0", DOUT, 19'h17000);
    for (int k = 0; k < 4; k++) tick();
    check("drain_pop", POP, 3'b000);

    // Owner stall after head; rr_ptr is 2 and only req1 has data
    held = fl(1'b0, C_HEAD, 16'h8100);
    q1.push_back(held);
    settle();
    check("wd_grant1", POP, 3'b010);
    tick();
    q0.push_back(fl(1'b0, C_HEAD, 16'h8000));
    q2.push_back(fl(1'b0, C_HEAD, 16'h8200));
    settle();
`ifdef ARB_WATCHDOG_EN
    for (int k = 0; k < 9; k++) begin
      check($sformatf("wd_stall_pop%0d", k), POP, 3'b000);
      tick();
      check($sformatf("wd_stall_lock%0d", k), LOCKED, 1);
    end
    tick();
    check("wd_timeout", TIMEOUT, 1);
    check("wd_unlocked", LOCKED, 0);
    check("wd_next_req2", POP, 3'b100);
`else
    for (int k = 0; k < 12; k++) tick();
    check("nowd_pop", POP, 3'b000);
    check("nowd_locked", LOCKED, 1);
    check("nowd_timeout", TIMEOUT, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ring_port_arbiter.md
RING_PORT_ARBITER -- requirements
Module: ring_port_arbiter

Interface
REQ-001 Parameter WD_LIMIT, default 8'd255, is the owner-stall cycle limit used only when the watchdog is compiled in.
REQ-002 CLK  input  1  the single clock; all state updates on posedge CLK.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 EMPTY  input  3  per-requester FIFO empty flags, 1 = no flit available; bit0 = local, bit1 = cw, bit2 = ccw.
REQ-005 DIN0, DIN1, DIN2  input  19 each  requester flit, valid combinationally in the cycle its POP bit is high; [18] dest flag, [17:16] ctrl (00 idle, 01 head, 10 body, 11 tail), [15:0] payload.
REQ-006 DST_FULL  input  1  downstream buffer full; 1 = no flit may be accepted this cycle.
REQ-007 POP  output  3  one-hot-or-zero read enable to the requester FIFOs.
REQ-008 DOUT  output  19  registered forwarded flit.
REQ-009 DOUT_VALID  output  1  registered write enable to downstream, high exactly one cycle per forwarded flit.
REQ-010 LOCKED  output  1  high while a packet owns the output.
REQ-011 OWNER  output  2  index of current or last owner, 0..2.
REQ-012 PROTO_ERR  output  1  sticky protocol-error flag.
REQ-013 TIMEOUT  output  1  sticky watchdog flag.

Function
REQ-014 POP shall be combinational from state, EMPTY and DST_FULL; at most one bit high; never high while DST_FULL=1.
REQ-015 Flit popped in cycle N shall appear on DOUT with DOUT_VALID=1 in cycle N+1 (latency 1); DOUT holds its last value when DOUT_VALID=0.
REQ-016 States: IDLE, LOCKED (2-state FSM).
REQ-017 IDLE: if DST_FULL=0 and any EMPTY bit is 0, grant the first non-empty requester searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); POP that requester; OWNER <= grantee.
REQ-018 IDLE grant with ctrl=01 -> LOCKED; ctrl=11 or 10 -> forward, stay IDLE, set PROTO_ERR, rr_ptr <= grantee+1 mod 3; ctrl=00 -> discard (DOUT_VALID stays 0), stay IDLE, no rr_ptr change.
REQ-019 LOCKED: only OWNER is eligible; POP[OWNER] when EMPTY[OWNER]=0 and DST_FULL=0; other requesters never popped.
REQ-020 LOCKED pop with ctrl=10 -> forward, stay; ctrl=11 -> forward, -> IDLE, rr_ptr <= OWNER+1 mod 3; ctrl=01 -> forward, stay, set PROTO_ERR; ctrl=00 -> discard, stay.
REQ-021 A new packet shall be grantable in the cycle after a tail pop (one IDLE cycle minimum between packets is permitted, not required: grant occurs in IDLE the cycle following the tail).
REQ-022 LOCKED output shall equal (state==LOCKED).
REQ-023 DST_FULL asserted mid-packet shall stall without state change; no flit lost or duplicated.
REQ-024 PROTO_ERR and TIMEOUT shall clear only by RST.

Reset
REQ-025 On RST=1 at a clock edge: state=IDLE, rr_ptr=0, OWNER=0, DOUT=19'h0, DOUT_VALID=0, PROTO_ERR=0, TIMEOUT=0, watchdog counter=0.
REQ-026 While RST=1, POP shall be 3'b000; RST mid-packet abandons the packet and the next grant starts from requester 0.

Configuration
REQ-027 Macro ARB_WATCHDOG_EN: when defined, an 8-bit counter increments each LOCKED cycle with EMPTY[OWNER]=1, clears on any owner pop or leaving LOCKED; on reaching WD_LIMIT the FSM forces IDLE, sets TIMEOUT, rr_ptr <= OWNER+1 mod 3.
REQ-028 When ARB_WATCHDOG_EN is undefined, no counter exists, TIMEOUT is constant 0, LOCKED is held indefinitely.

Verification
REQ-029 All EMPTY=0, each requester sends single 2-flit packets (01,11), DST_FULL=0 -> grant order 0,1,2,0,... and DOUT_VALID one cycle after each POP.
REQ-030 Req1 sends head/body/body/tail, req0 non-empty meanwhile -> POP[0]=0 until req1 tail forwarded; next grant to req2 if non-empty else req0.
REQ-031 DST_FULL=1 for 5 cycles mid-packet -> POP=000 those cycles, DOUT_VALID=0, DOUT sequence unchanged after release.
REQ-032 Req2 flit ctrl=10 while IDLE -> forwarded, PROTO_ERR=1 next cycle and stays 1; ctrl=00 flit -> popped, DOUT_VALID=0.
REQ-033 RST during LOCKED on req2 -> next cycle state IDLE, OWNER=0, DOUT=0, grant from requester 0 first.
REQ-034 With ARB_WATCHDOG_EN, WD_LIMIT=8'd10: head from req1 then EMPTY[1]=1 -> TIMEOUT=1 after 10 stall cycles, LOCKED=0, next grant to req2.
